hazard_ctrl: RTL

Pipeline sequencer for the 5-stage RV32I_Zicsr core. It pairs with the EX-stage forwarding unit and covers the hazards forwarding cannot resolve:
- load-use stalls
- taken-branch/jump flushes
- data-memory wait states with timeout
- trap entry drain for CSR/mtvec redirect

It drives per-stage stall/flush enables and the PC source select.

---
 rtl/hazard_ctrl_pkg.sv | 15 +
 rtl/hazard_loaduse_cmp.sv | 19 +
 rtl/hazard_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard sequencer: register-address width,
// PC source selects and FSM state encoding.
package hazard_ctrl_pkg;
  localparam int XADDR_W = 5;

  localparam logic [1:0] PCSEL_SEQ  = 2'd0;
  localparam logic [1:0] PCSEL_BR   = 2'd1;
  localparam logic [1:0] PCSEL_TRAP = 2'd2;

  typedef enum logic [1:0] {
    HZ_RUN        = 2'd0,
    HZ_MEM_WAIT   = 2'd1,
    HZ_TRAP_DRAIN = 2'd2
  } hz_state_e;
endpackage

// File: rtl/hazard_loaduse_cmp.sv
// Combinational read-after-write compare between a producer in a later stage
// and the source operands of the ID instruction; x0 never hazards.
module hazard_loaduse_cmp
  import hazard_ctrl_pkg::*;
(
  input  logic [XADDR_W-1:0] rs1,
  input  logic [XADDR_W-1:0] rs2,
  input  logic               rs1_used,
  input  logic               rs2_used,
  input  logic [XADDR_W-1:0] rd,
  input  logic               rd_wr_en,
  input  logic               producer,
  output logic               hit
);
  logic rd_live;

  assign rd_live = producer & rd_wr_en & (rd != '0);
  assign hit     = rd_live & ((rs1_used & (rs1 == rd)) | (rs2_used & (rs2 == rd)));
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use stalls, branch flushes, data-memory wait with
// timeout-to-trap, and the post-trap drain of IF/ID.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int TRAP_DRAIN  = 2,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [XADDR_W-1:0] i_rs1_addr_id,
  input  logic [XADDR_W-1:0] i_rs2_addr_id,
  input  logic               i_rs1_used_id,
  input  logic               i_rs2_used_id,
  input  logic [XADDR_W-1:0] i_rd_addr_ex,
  input  logic               i_rd_wr_en_ex,
  input  logic               i_load_ex,
  input  logic               i_branch_taken_ex,
  input  logic               i_dmem_req_mem,
  input  logic               i_dmem_ack,
  input  logic               i_trap_req_mem,
  output logic               o_stall_if,
  output logic               o_stall_id,
  output logic               o_stall_ex,
  output logic               o_stall_mem,
  output logic               o_flush_id,
  output logic               o_flush_ex,
  output logic               o_flush_mem,
  output logic [1:0]         o_pc_sel,
  output logic               o_mem_fault,
  output logic [1:0]         o_state
);
  hz_state_e  state, state_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic [3:0] drain_cnt, drain_nxt;
  logic       lu_hit;

  hazard_loaduse_cmp u_lu (
    .rs1      (i_rs1_addr_id),
    .rs2      (i_rs2_addr_id),
    .rs1_used (i_rs1_used_id),
    .rs2_used (i_rs2_used_id),
    .rd       (i_rd_addr_ex),
    .rd_wr_en (i_rd_wr_en_ex),
    .producer (i_load_ex),
    .hit      (lu_hit)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= HZ_RUN;
      wait_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    drain_nxt   = drain_cnt;
    o_stall_if  = 1'b0;
    o_stall_id  = 1'b0;
    o_stall_ex  = 1'b0;
    o_stall_mem = 1'b0;
    o_flush_id  = 1'b0;
    o_flush_ex  = 1'b0;
    o_flush_mem = 1'b0;
    o_pc_sel    = PCSEL_SEQ;
    o_mem_fault = 1'b0;
    case (state)
      HZ_RUN: begin
        if (i_trap_req_mem) begin
          {o_flush_id, o_flush_ex, o_flush_mem} = 3'b111;
          o_pc_sel  = PCSEL_TRAP;
          state_nxt = HZ_TRAP_DRAIN;
          drain_nxt = 4'(TRAP_DRAIN - 1);
        end else if (i_dmem_req_mem && !i_dmem_ack) begin
          // Taken branch in EX is frozen along with everything else.
          {o_stall_if, o_stall_id, o_stall_ex, o_stall_mem} = 4'hf;
          o_flush_mem = 1'b1;
          state_nxt   = HZ_MEM_WAIT;
          wait_nxt    = 8'd1;
        end else if (i_branch_taken_ex) begin
          {o_flush_id, o_flush_ex} = 2'b11;
          o_pc_sel = PCSEL_BR;
        end else if (lu_hit) begin
          {o_stall_if, o_stall_id, o_flush_id} = 3'b111;
        end
      end
      HZ_MEM_WAIT: begin
        if (i_dmem_ack) begin
          state_nxt = HZ_RUN;
          wait_nxt  = '0;
        end else if (wait_cnt == 8'(MEM_TIMEOUT)) begin
          o_mem_fault = 1'b1;
          {o_flush_id, o_flush_ex, o_flush_mem} = 3'b111;
          o_pc_sel  = PCSEL_TRAP;
          state_nxt = HZ_TRAP_DRAIN;
          drain_nxt = 4'(TRAP_DRAIN - 1);
          wait_nxt  = '0;
        end else begin
          {o_stall_if, o_stall_id, o_stall_ex, o_stall_mem} = 4'hf;
          o_flush_mem = 1'b1;
          wait_nxt    = wait_cnt + 8'd1;
        end
      end
      HZ_TRAP_DRAIN: begin
        o_stall_if = 1'b1;
        o_flush_id = 1'b1;
        if (drain_cnt == '0) state_nxt = HZ_RUN;
        else                 drain_nxt = drain_cnt - 4'd1;
      end
      default: state_nxt = HZ_RUN;
    endcase
    // Reset holds every stage in bubble regardless of the registered state.
    if (i_rst) begin
      {o_stall_if, o_stall_id, o_stall_ex, o_stall_mem} = 4'h0;
      {o_flush_id, o_flush_ex, o_flush_mem} = 3'b111;
      o_pc_sel    = PCSEL_SEQ;
      o_mem_fault = 1'b0;
    end
  end

  assign o_state = state;
endmodule
